// File: rtl/asrv32_decode_queue.sv
// asrv32_decode_queue
//   DEPTH-entry instruction FIFO (valid/ready on both sides) feeding a single
//   registered decode slot (the ID/EX register). The FIFO head is decoded
//   combinationally and captured whenever the slot is free.
//   Optional RV32M decode is enabled by defining the macro ASRV32_MEXT_EN.
//
//   One-hot bit maps:
//     o_opcode    : 0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL,
//                   6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE
//     o_alu_op    : 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL,
//                   7 SRA, 8 OR, 9 AND, 10 EQ, 11 NEQ, 12 GE, 13 GEU
//     o_exception : 0 ILLEGAL, 1 ECALL, 2 EBREAK, 3 MRET

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module asrv32_decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [31:0]                 i_inst,
    input  logic [31:0]                 i_pc,
    input  logic                        i_flush,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [31:0]                 o_pc,
    output logic [4:0]                  o_rs1_addr,
    output logic [4:0]                  o_rs2_addr,
    output logic [4:0]                  o_rd_addr,
    output logic [31:0]                 o_imm,
    output logic [2:0]                  o_funct3,
    output logic [`OPCODE_WIDTH-1:0]    o_opcode,
    output logic [`ALU_WIDTH-1:0]       o_alu_op,
    output logic [`EXCEPTION_WIDTH-1:0] o_exception,
    output logic                        o_muldiv,
    output logic [CNT_W-1:0]            o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NEQ  = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_MRET    = 3;

`ifdef ASRV32_MEXT_EN
    localparam bit MEXT_EN = 1'b1;
`else
    localparam bit MEXT_EN = 1'b0;
`endif

    // FIFO storage: {pc, inst} per entry
    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        slot_free;
    logic [31:0] head_inst;
    logic [31:0] head_pc;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign o_ready   = !full;
    assign o_count   = count_reg;
    assign slot_free = !o_valid || i_ready;
    assign push      = i_valid && !full;
    assign pop       = slot_free && !empty;
    assign {head_pc, head_inst} = mem[rd_ptr_reg];

    // Entry write; storage needs no reset because occupancy gates every read
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && push) begin
            mem[wr_ptr_reg] <= {i_pc, i_inst};
        end
    end

    // Pointers and occupancy: reset over flush over push/pop
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Decode of the FIFO head
    logic [6:0]                  opc;
    logic [2:0]                  f3;
    logic [6:0]                  f7;
    logic [31:0]                 imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;
    logic [3:0]                  arith_sel;
    logic [3:0]                  alu_sel;
    logic                        alu_none;
    logic [`OPCODE_WIDTH-1:0]    dec_opcode;
    logic [`ALU_WIDTH-1:0]       dec_alu;
    logic [31:0]                 dec_imm;
    logic [`EXCEPTION_WIDTH-1:0] dec_exc;
    logic                        dec_muldiv;

    assign opc   = head_inst[6:0];
    assign f3    = head_inst[14:12];
    assign f7    = head_inst[31:25];
    assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                    head_inst[30:25], head_inst[11:8], 1'b0};
    assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                    head_inst[20], head_inst[30:21], 1'b0};
    assign imm_u = {head_inst[31:12], 12'b0};
    assign imm_z = {20'b0, head_inst[31:20]};

    // Arithmetic op shared by R and I formats; inst[30] picks SRA over SRL
    always_comb begin
        arith_sel = ALU_ADD;
        case (f3)
            3'b000:  arith_sel = ALU_ADD;
            3'b001:  arith_sel = ALU_SLL;
            3'b010:  arith_sel = ALU_SLT;
            3'b011:  arith_sel = ALU_SLTU;
            3'b100:  arith_sel = ALU_XOR;
            3'b101:  arith_sel = head_inst[30] ? ALU_SRA : ALU_SRL;
            3'b110:  arith_sel = ALU_OR;
            default: arith_sel = ALU_AND;
        endcase
    end

    // Major-opcode decode: type, ALU op, immediate and exception flags
    always_comb begin
        dec_opcode = '0;
        dec_imm    = '0;
        dec_exc    = '0;
        dec_muldiv = 1'b0;
        alu_sel    = ALU_ADD;
        alu_none   = 1'b0;
        case (opc)
            7'b0110011: begin
                dec_opcode[OP_RTYPE] = 1'b1;
                alu_sel = (f3 == 3'b000 && head_inst[30]) ? ALU_SUB : arith_sel;
                if (MEXT_EN && f7 == 7'b0000001) begin
                    dec_muldiv = 1'b1;
                    alu_none   = 1'b1;
                end else if (f7 != 7'b0000000 && f7 != 7'b0100000) begin
                    dec_exc[EXC_ILLEGAL] = 1'b1;
                end
            end
            7'b0010011: begin
                dec_opcode[OP_ITYPE] = 1'b1;
                alu_sel = arith_sel;
                dec_imm = imm_i;
                if ((f3 == 3'b001 || f3 == 3'b101) && head_inst[25])
                    dec_exc[EXC_ILLEGAL] = 1'b1;
            end
            7'b0000011: begin
                dec_opcode[OP_LOAD] = 1'b1;
                dec_imm = imm_i;
            end
            7'b0100011: begin
                dec_opcode[OP_STORE] = 1'b1;
                dec_imm = imm_s;
            end
            7'b1100011: begin
                dec_opcode[OP_BRANCH] = 1'b1;
                dec_imm = imm_b;
                case (f3)
                    3'b000:  alu_sel = ALU_EQ;
                    3'b001:  alu_sel = ALU_NEQ;
                    3'b100:  alu_sel = ALU_SLT;
                    3'b101:  alu_sel = ALU_GE;
                    3'b110:  alu_sel = ALU_SLTU;
                    3'b111:  alu_sel = ALU_GEU;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            7'b1101111: begin
                dec_opcode[OP_JAL] = 1'b1;
                dec_imm = imm_j;
            end
            7'b1100111: begin
                dec_opcode[OP_JALR] = 1'b1;
                dec_imm = imm_i;
            end
            7'b0110111: begin
                dec_opcode[OP_LUI] = 1'b1;
                dec_imm = imm_u;
            end
            7'b0010111: begin
                dec_opcode[OP_AUIPC] = 1'b1;
                dec_imm = imm_u;
            end
            7'b1110011: begin
                dec_opcode[OP_SYSTEM] = 1'b1;
                dec_imm = imm_z;
                if (f3 == 3'b000) begin
                    case (head_inst[21:20])
                        2'b00:   dec_exc[EXC_ECALL]  = 1'b1;
                        2'b01:   dec_exc[EXC_EBREAK] = 1'b1;
                        2'b10:   dec_exc[EXC_MRET]   = 1'b1;
                        default: dec_exc = '0;
                    endcase
                end
            end
            7'b0001111: begin
                dec_opcode[OP_FENCE] = 1'b1;
                dec_imm = imm_z;
            end
            default: begin
                dec_exc[EXC_ILLEGAL] = 1'b1;
            end
        endcase
        dec_alu = alu_none ? '0 : (`ALU_WIDTH'(1) << alu_sel);
    end

    // Output slot: load on free slot; data holds when nothing new arrives
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_pc        <= '0;
            o_rs1_addr  <= '0;
            o_rs2_addr  <= '0;
            o_rd_addr   <= '0;
            o_imm       <= '0;
            o_funct3    <= '0;
            o_opcode    <= '0;
            o_alu_op    <= '0;
            o_exception <= '0;
            o_muldiv    <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (slot_free) begin
            o_valid <= !empty;
            if (!empty) begin
                o_pc        <= head_pc;
                o_rs1_addr  <= head_inst[19:15];
                o_rs2_addr  <= head_inst[24:20];
                o_rd_addr   <= head_inst[11:7];
                o_imm       <= dec_imm;
                o_funct3    <= f3;
                o_opcode    <= dec_opcode;
                o_alu_op    <= dec_alu;
                o_exception <= dec_exc;
                o_muldiv    <= dec_muldiv;
            end
        end
    end

endmodule
